in3_or_gate: RTL and testbench
==============================

IN3_OR_GATE -- requirements
Module: in3_or_gate

Interface
REQ-001 Parameter CNT_W, default 16: width of the statistics counters.
REQ-002 clk  input  1  single clock; all registers update on rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a  input  1  OR operand 0.
REQ-005 b  input  1  OR operand 1.
REQ-006 c  input  1  OR operand 2.
REQ-007 out  output  1  combinational a|b|c.
REQ-008 out_q  output  1  out registered by one clk.
REQ-009 rise  output  1  one-cycle pulse, out_q 0->1.
REQ-010 fall  output  1  one-cycle pulse, out_q 1->0.
REQ-011 src_q  output  3  registered {c,b,a} snapshot.
REQ-012 hit_cnt  output  CNT_W  saturating count of cycles with out=1.
REQ-013 Port declaration order: a, b, c, out, clk, rst, out_q, rise, fall, src_q, hit_cnt.
- The first four must stay positional-compatible with a 4-port instantiation (a, b, c, out).

Function
REQ-014 out = a OR b OR c, purely combinational.
- Zero-cycle latency.
- Independent of clk, rst and the macro.
- Correct even when clk/rst are unconnected or X.
REQ-015 Truth table: out=0 only for a=b=c=0; all seven other combinations give out=1.
REQ-016 out_q takes the value of out sampled at each rising clk edge (latency 1 cycle).
REQ-017 src_q takes {c,b,a} at each rising clk edge.
REQ-018 rise=1 for exactly the cycle following an edge where out_q went 0->1.
- Implemented as out_q & ~out_q_prev (out_q_prev is an internal register).
REQ-019 fall=1 for exactly the cycle where out_q & ~out_q_prev is replaced by ~out_q & out_q_prev.
- rise and fall are never both 1.
REQ-020 hit_cnt increments by 1 on each rising edge where out=1.
- Saturates at 2^CNT_W-1 and never wraps.
REQ-021 Input glitches between clock edges affect out only, never registered outputs.

Reset
REQ-022 On a rising clk edge with rst=1:
- out_q=0, out_q_prev=0, src_q=3'b000, hit_cnt=0.
- rise and fall are driven 0.
REQ-023 Reset has priority over all updates, including a hit_cnt increment in the same cycle.
REQ-024 Reset does not affect out.
REQ-025 Release: the first edge with rst=0 samples the inputs normally.
- rise can assert on the cycle after release if out=1 at that edge.
REQ-026 Reset asserted mid-operation clears state at the next edge, with no residual pulses.

Configuration
REQ-027 Macro IN3_OR_GATE_STATS_EN.
- Defined: hit_cnt logic per REQ-020 is compiled in.
- Undefined: no counter registers are built and hit_cnt is tied to 0.
- All other behaviour is identical in both builds.

Verification
REQ-028 No clock, rst unconnected; step {a,b,c} 000..111 every 10 time units -> out = 0,1,1,1,1,1,1,1 within the same time step.
REQ-029 rst=1 for 2 cycles with a=1 -> out=1, out_q=0, hit_cnt=0, src_q=000; release -> next edge out_q=1, src_q=001, rise=1 for one cycle.
REQ-030 Hold a=b=c=1 for 5 cycles, then 000 -> hit_cnt=5 (STATS_EN); fall=1 exactly once, on the cycle after out_q returns to 0.
REQ-031 CNT_W=3, out=1 for 10 cycles -> hit_cnt stops at 7.
REQ-032 rst asserted while out=1 and hit_cnt=4 -> next edge hit_cnt=0, out_q=0, no rise/fall pulse.
REQ-033 Build without IN3_OR_GATE_STATS_EN, repeat REQ-030 -> hit_cnt stays 0; out, out_q, rise, fall unchanged.

Source files
------------

// File: rtl/in3_or_gate.sv
// Three-input OR gate with registered output, edge pulses, input snapshot and
// an optional saturating hit counter (compiled in when IN3_OR_GATE_STATS_EN is defined).
module in3_or_gate #(
  parameter int CNT_W = 16
) (
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             out,
  input  logic             clk,
  input  logic             rst,
  output logic             out_q,
  output logic             rise,
  output logic             fall,
  output logic [2:0]       src_q,
  output logic [CNT_W-1:0] hit_cnt
);

  logic       w_or;
  logic       r_out_q;
  logic       r_out_q_prev;
  logic [2:0] r_src_q;

  // The gate itself depends on nothing but the operands, so it stays valid
  // even with the clock stopped or reset floating.
  assign w_or = a | b | c;
  assign out  = w_or;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q      <= 1'b0;
      r_out_q_prev <= 1'b0;
      r_src_q      <= 3'b000;
    end else begin
      r_out_q      <= w_or;
      r_out_q_prev <= r_out_q;
      r_src_q      <= {c, b, a};
    end
  end

  assign out_q = r_out_q;
  assign src_q = r_src_q;
  // Both history bits clear together on reset, so no pulse survives it.
  assign rise  = r_out_q & ~r_out_q_prev;
  assign fall  = ~r_out_q & r_out_q_prev;

`ifdef IN3_OR_GATE_STATS_EN
  logic [CNT_W-1:0] r_hit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt <= '0;
    end else if (w_or && (r_hit_cnt != {CNT_W{1'b1}})) begin
      r_hit_cnt <= r_hit_cnt + CNT_W'(1);
    end
  end

  assign hit_cnt = r_hit_cnt;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_in3_or_gate.sv
// Directed self-checking bench for in3_or_gate; expected hit counts follow
// whether IN3_OR_GATE_STATS_EN is defined for this build.
module tb_in3_or_gate;

`ifdef IN3_OR_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  bit          clk_run = 1'b0;
  logic        rst;
  logic        a, b, c;
  logic        out, out_q, rise, fall;
  logic [2:0]  src_q;
  logic [15:0] hit_cnt;
  logic        s_out, s_out_q, s_rise, s_fall;
  logic [2:0]  s_src_q;
  logic [2:0]  s_hit_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int falls_seen = 0;

  in3_or_gate #(.CNT_W(16)) u_dut (
    .a(a), .b(b), .c(c), .out(out), .clk(clk), .rst(rst),
    .out_q(out_q), .rise(rise), .fall(fall), .src_q(src_q), .hit_cnt(hit_cnt)
  );

  in3_or_gate #(.CNT_W(3)) u_sat (
    .a(a), .b(b), .c(c), .out(s_out), .clk(clk), .rst(rst),
    .out_q(s_out_q), .rise(s_rise), .fall(s_fall), .src_q(s_src_q), .hit_cnt(s_hit_cnt)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_hit(input int n, input int maxv);
    if (!STATS) return 32'd0;
    return (n > maxv) ? 32'(maxv) : 32'(n);
  endfunction

  initial begin
    logic [7:0] or_tbl;
    logic [2:0] abc;
    or_tbl = 8'b1111_1110;

    // Clock stopped, reset never driven: the gate alone must respond.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      {a, b, c} = abc;
      #1;
      check($sformatf("comb_or_%0d", i), 32'(out), 32'(or_tbl[i]));
      #9;
    end

    // Reset held two cycles with a=1, then release.
    clk_run = 1'b1;
    {a, b, c} = 3'b100;
    rst = 1'b1;
    tick();
    tick();
    check("rst_out",     32'(out),     32'd1);
    check("rst_out_q",   32'(out_q),   32'd0);
    check("rst_hit",     32'(hit_cnt), 32'd0);
    check("rst_src_q",   32'(src_q),   32'd0);
    check("rst_rise",    32'(rise),    32'd0);
    check("rst_fall",    32'(fall),    32'd0);
    rst = 1'b0;
    tick();
    check("rel_out_q",   32'(out_q),   32'd1);
    check("rel_src_q",   32'(src_q),   32'b001);
    check("rel_rise",    32'(rise),    32'd1);
    check("rel_hit",     32'(hit_cnt), exp_hit(1, 65535));
    tick();
    check("rel_rise_end", 32'(rise),   32'd0);
    check("rel_hit2",    32'(hit_cnt), exp_hit(2, 65535));

    // Five cycles of 111 then 000; glitch between edges in the middle.
    {a, b, c} = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("idle_out_q",  32'(out_q),   32'd0);
    check("idle_hit",    32'(hit_cnt), 32'd0);
    {a, b, c} = 3'b111;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("hold_out_q_%0d", i), 32'(out_q), 32'd1);
      check($sformatf("hold_rise_%0d", i),  32'(rise),  (i == 1) ? 32'd1 : 32'd0);
      check($sformatf("hold_fall_%0d", i),  32'(fall),  32'd0);
      if (i == 3) begin
        {a, b, c} = 3'b000;
        #1;
        check("glitch_out",   32'(out),   32'd0);
        check("glitch_out_q", 32'(out_q), 32'd1);
        check("glitch_src_q", 32'(src_q), 32'b111);
        {a, b, c} = 3'b111;
      end
    end
    check("hold_src_q",  32'(src_q),   32'b111);
    check("hold_hit",    32'(hit_cnt), exp_hit(5, 65535));
    {a, b, c} = 3'b000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (fall === 1'b1) falls_seen++;
      check($sformatf("drop_fall_%0d", i), 32'(fall),    (i == 1) ? 32'd1 : 32'd0);
      check($sformatf("drop_rise_%0d", i), 32'(rise),    32'd0);
      check($sformatf("drop_out_q_%0d", i), 32'(out_q),  32'd0);
      check($sformatf("drop_hit_%0d", i),  32'(hit_cnt), exp_hit(5, 65535));
    end
    check("fall_once", 32'(falls_seen), 32'd1);

    // Saturation: ten hit cycles into a 3-bit counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    {a, b, c} = 3'b010;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 6) check($sformatf("sat_hit_%0d", i), 32'(s_hit_cnt), exp_hit(i, 7));
    end
    check("sat_wide_hit", 32'(hit_cnt), exp_hit(10, 65535));
    check("sat_out",      32'(s_out),   32'd1);
    check("sat_out_q",    32'(s_out_q), 32'd1);
    check("sat_src_q",    32'(s_src_q), 32'b010);
    check("sat_rise",     32'(s_rise),  32'd0);
    check("sat_fall",     32'(s_fall),  32'd0);

    // Reset in the middle of activity with hit_cnt at 4.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    {a, b, c} = 3'b001;
    for (int i = 0; i < 4; i++) tick();
    check("mid_pre_hit",   32'(hit_cnt), exp_hit(4, 65535));
    check("mid_pre_out_q", 32'(out_q),   32'd1);
    rst = 1'b1;
    tick();
    check("mid_hit",   32'(hit_cnt), 32'd0);
    check("mid_out_q", 32'(out_q),   32'd0);
    check("mid_src_q", 32'(src_q),   32'd0);
    check("mid_rise",  32'(rise),    32'd0);
    check("mid_fall",  32'(fall),    32'd0);
    check("mid_out",   32'(out),     32'd1);
    tick();
    check("mid_hold_fall", 32'(fall), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rise",  32'(rise),    32'd1);
    check("post_src_q", 32'(src_q),   32'b100);
    check("post_hit",   32'(hit_cnt), exp_hit(1, 65535));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
